codemem_loader: RTL and testbench

- Boot/program-load controller for the 64 x 16-bit code memory.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instructions (high byte first), and drives the code memory write port.
- Holds the CPU halted during load and releases it once the programmed count of words is written.
- Sits between the host/serial byte source and the code memory; its run outputs gate the code memory and the PC.

---
 rtl/codemem_pkg.sv | 18 +
 rtl/codemem_loader_byte_packer.sv | 39 +++
 rtl/codemem_loader.sv | 180 ++++++++++++++++++
 tb/tb_codemem_loader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codemem_pkg.sv
// Shared constants and loader state encoding for the code memory
// boot loader (codemem_loader and its byte_packer helper).
package codemem_pkg;

    localparam int CODE_ADDR_W = 6;
    localparam int CODE_DEPTH  = 64;
    localparam int INSTR_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
        GET_SUM,
        FINISH
    } load_state_t;

endpackage

// File: rtl/codemem_loader_byte_packer.sv
// byte_packer: registered byte_ready plus hi/lo byte capture.
// Ports: clock/reset; ready_next, cap_hi, cap_lo from the loader FSM;
// byte_valid/byte_data/byte_ready stream side; fire = accepted byte;
// word = {hi, lo} assembled instruction.
module byte_packer
    import codemem_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ready_next,
    input  logic               cap_hi,
    input  logic               cap_lo,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               fire,
    output logic [INSTR_W-1:0] word
);

    logic [7:0] hi;
    logic [7:0] lo;

    assign fire = byte_valid & byte_ready;
    assign word = {hi, lo};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_ready <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            // ready follows the state being entered, so it is a clean flop
            byte_ready <= ready_next;
            if (fire && cap_hi) hi <= byte_data;
            if (fire && cap_lo) lo <= byte_data;
        end
    end

endmodule

// File: rtl/codemem_loader.sv
// codemem_loader: loads a byte stream into the 64x16 code memory and
// holds the CPU halted until the programmed number of words is written.
// Ports: clock, reset (async, active-low); start + word_count begin a
// session; byte_valid/byte_data/byte_ready byte stream; mem_we,
// mem_waddr, mem_wdata, mem_run code memory side; cpu_run, busy, done,
// load_err status. Define CODEMEM_LOADER_CHECKSUM_EN to require a
// trailing checksum byte making the modulo-256 byte sum zero.
module codemem_loader
    import codemem_pkg::*;
#(
    parameter int ADDR_W = CODE_ADDR_W,
    parameter int DEPTH  = CODE_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               mem_run,
    output logic               cpu_run,
    output logic               busy,
    output logic               done,
    output logic               load_err
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    load_state_t        state;
    load_state_t        state_next;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W:0]    count;
    logic [INSTR_W-1:0] word;
    logic               fire;
    logic               ready_next;
    logic               cap_hi;
    logic               cap_lo;
    logic               count_ok;
    logic               last;
    logic               do_load;
    logic               do_bad;
    logic               do_step;
    logic               do_fail;

    assign count_ok = (word_count != '0) && (word_count <= DEPTH_W);
    assign last     = ({1'b0, addr} == (count - C_ONE));

`ifdef CODEMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       sum_ok;

    assign sum_ok = ((sum + byte_data) == 8'h00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (do_load) begin
            sum <= '0;
        end else if (fire && (cap_hi || cap_lo)) begin
            sum <= sum + byte_data;
        end
    end
`endif

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .ready_next (ready_next),
        .cap_hi     (cap_hi),
        .cap_lo     (cap_lo),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .fire       (fire),
        .word       (word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        mem_we     = 1'b0;
        do_load    = 1'b0;
        do_bad     = 1'b0;
        do_step    = 1'b0;
        do_fail    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count_ok) begin
                        do_load    = 1'b1;
                        state_next = GET_HI;
                    end else begin
                        do_bad = 1'b1;
                    end
                end
            end
            GET_HI: begin
                cap_hi = 1'b1;
                if (fire) state_next = GET_LO;
            end
            GET_LO: begin
                cap_lo = 1'b1;
                if (fire) state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (last) begin
`ifdef CODEMEM_LOADER_CHECKSUM_EN
                    state_next = GET_SUM;
`else
                    state_next = FINISH;
`endif
                end else begin
                    do_step    = 1'b1;
                    state_next = GET_HI;
                end
            end
            GET_SUM: begin
`ifdef CODEMEM_LOADER_CHECKSUM_EN
                if (fire) begin
                    if (sum_ok) begin
                        state_next = FINISH;
                    end else begin
                        do_fail    = 1'b1;
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready_next = (state_next == GET_HI) ||
                        (state_next == GET_LO) ||
                        (state_next == GET_SUM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            count    <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (do_load) begin
                count    <= word_count;
                addr     <= '0;
                done     <= 1'b0;
                load_err <= 1'b0;
            end
            if (do_bad || do_fail) load_err <= 1'b1;
            if (do_step) addr <= addr + A_ONE;
            if (state == FINISH) done <= 1'b1;
        end
    end

    assign busy      = (state == GET_HI) || (state == GET_LO) ||
                       (state == WRITE)  || (state == GET_SUM);
    assign cpu_run   = (state == IDLE) && done;
    // the code memory drops writes unless it is enabled
    assign mem_run   = cpu_run || mem_we;
    assign mem_waddr = addr;
    assign mem_wdata = mem_we ? word : '0;

endmodule

// File: tb/tb_codemem_loader.sv
// Self-checking bench for codemem_loader: random programs are streamed
// in and the observed write stream is compared with the program image.
module tb_codemem_loader;

    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          mem_run;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          load_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bad_run = 0;
    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    logic [15:0] prog[$];

    codemem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_run    (mem_run),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_waddr));
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
            if (mem_run !== 1'b1) bad_run <= bad_run + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: time=%0t limit=500000", $time);
        $fatal(1, "hang");
    end

    function automatic logic [7:0] prog_csum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + prog[i][15:8] + prog[i][7:0];
        return 8'h00 - s;
    endfunction

    task automatic pulse_start(input int wc);
        start = 1'b1;
        word_count = (AW + 1)'(wc);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int max_gap);
        bit ok = 1'b0;
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (byte_ready === 1'b1) begin
                @(posedge clock); #1;
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept: byte %02h got ready=0 want ready=1", b);
        end
    endtask

    task automatic send_words(input int n, input int max_gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (i == start_at) begin
                byte_valid = 1'b0;
                pulse_start(2);
            end
            drive_byte(prog[i][15:8], max_gap);
            drive_byte(prog[i][7:0], max_gap);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_idle: busy=%b want 0", busy);
        end
        @(negedge clock);
        @(posedge clock); #1;
    endtask

    task automatic end_session(input int n);
`ifdef CODEMEM_LOADER_CHECKSUM_EN
        drive_byte(prog_csum(n), 0);
        byte_valid = 1'b0;
`else
        if (n < 0) $display("unused %0d", n);
`endif
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({byte_ready, mem_we, mem_waddr, mem_wdata, mem_run,
             cpu_run, busy, done, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b rdy=%b busy=%b done=%b err=%b run=%b want all 0",
                     mem_we, byte_ready, busy, done, load_err, cpu_run);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({byte_ready, busy, done, cpu_run, mem_run} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b done=%b cpu=%b want 0",
                     byte_ready, busy, done, cpu_run);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int base = wr_addr.size();
        int rb = bad_run;
        prog.delete();
        prog.push_back(16'h1234);
        prog.push_back(16'h5678);
        prog.push_back(16'h9ABC);
        pulse_start(3);
        send_words(3, 0, -1);
`ifdef CODEMEM_LOADER_CHECKSUM_EN
        drive_byte(prog_csum(3), 0);
        byte_valid = 1'b0;
`else
        @(negedge clock);
        checks++;
        if (mem_we !== 1'b1 || busy !== 1'b1 || mem_run !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_latency: we=%b busy=%b run=%b want 1 1 1",
                     mem_we, busy, mem_run);
        end
`endif
        @(negedge clock);
        checks++;
        if ({busy, done, cpu_run, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_finish: busy=%b done=%b cpu=%b we=%b want 0000",
                     busy, done, cpu_run, mem_we);
        end
        @(negedge clock);
        checks++;
        if ({done, cpu_run, mem_run, load_err, busy} !== 5'b11100) begin
            errors++;
            $display("FAIL basic_release: done=%b cpu=%b mrun=%b err=%b busy=%b want 11100",
                     done, cpu_run, mem_run, load_err, busy);
        end
        @(posedge clock); #1;
        checks++;
        if (wr_addr.size() - base != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d writes want 3", wr_addr.size() - base);
        end
        for (int i = 0; i < 3 && base + i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[base + i] != i || wr_data[base + i] !== prog[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got %04h@%0d want %04h@%0d",
                         i, wr_data[base + i], wr_addr[base + i], prog[i], i);
            end
        end
        checks++;
        if (bad_run != rb) begin
            errors++;
            $display("FAIL basic_mem_run: got %0d writes without mem_run want 0", bad_run - rb);
        end
    endtask

    task automatic test_full();
        int base = wr_addr.size();
        int rb = bad_run;
        int bad = 0;
        int slow = 0;
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(16'($urandom));
        pulse_start(64);
        send_words(64, 0, -1);
        end_session(64);
        checks++;
        if (wr_addr.size() - base != 64) begin
            errors++;
            $display("FAIL full_count: got %0d writes want 64", wr_addr.size() - base);
        end
        for (int i = 0; i < 64 && base + i < wr_addr.size(); i++) begin
            if (wr_addr[base + i] != i || wr_data[base + i] !== prog[i]) bad++;
            if (i > 0 && wr_cyc[base + i] - wr_cyc[base + i - 1] != 3) slow++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_data: got %0d wrong writes want 0", bad);
        end
        checks++;
        if (slow != 0) begin
            errors++;
            $display("FAIL full_rate: got %0d gaps not 3 cycles want 0", slow);
        end
        checks++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || bad_run != rb) begin
            errors++;
            $display("FAIL full_done: done=%b cpu=%b norun=%0d want 1 1 0",
                     done, cpu_run, bad_run - rb);
        end
    endtask

    task automatic test_gaps();
        int base = wr_addr.size();
        int bad = 0;
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(16'($urandom));
        pulse_start(8);
        send_words(8, 3, 3);
        end_session(8);
        checks++;
        if (wr_addr.size() - base != 8) begin
            errors++;
            $display("FAIL gaps_count: got %0d writes want 8", wr_addr.size() - base);
        end
        for (int i = 0; i < 8 && base + i < wr_addr.size(); i++)
            if (wr_addr[base + i] != i || wr_data[base + i] !== prog[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gaps_data: got %0d wrong writes want 0", bad);
        end
        checks++;
        if (done !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done: done=%b err=%b want 1 0", done, load_err);
        end
    endtask

    task automatic test_bad_count();
        int base = wr_addr.size();
        pulse_start(0);
        @(negedge clock);
        checks++;
        if ({load_err, busy, byte_ready} !== 3'b100) begin
            errors++;
            $display("FAIL bad_zero: err=%b busy=%b rdy=%b want 100",
                     load_err, busy, byte_ready);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        pulse_start(65);
        repeat (4) @(negedge clock);
        checks++;
        if ({load_err, busy, byte_ready, done, cpu_run} !== 5'b10000) begin
            errors++;
            $display("FAIL bad_65: err=%b busy=%b rdy=%b done=%b cpu=%b want 10000",
                     load_err, busy, byte_ready, done, cpu_run);
        end
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL bad_nowrite: got %0d writes want 0", wr_addr.size() - base);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort();
        int base = wr_addr.size();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(16'($urandom));
        pulse_start(5);
        send_words(2, 1, -1);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_we, mem_waddr, mem_wdata, mem_run,
             cpu_run, busy, done, load_err} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: rdy=%b busy=%b addr=%0d done=%b want all 0",
                     byte_ready, busy, mem_waddr, done);
        end
        checks++;
        if (wr_addr.size() - base != 2) begin
            errors++;
            $display("FAIL abort_count: got %0d writes want 2", wr_addr.size() - base);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        base = wr_addr.size();
        prog.delete();
        prog.push_back(16'($urandom));
        prog.push_back(16'($urandom));
        pulse_start(2);
        send_words(2, 2, -1);
        end_session(2);
        checks++;
        if (wr_addr.size() - base != 2 ||
            wr_addr[base] != 0 || wr_data[base] !== prog[0] ||
            wr_addr[base + 1] != 1 || wr_data[base + 1] !== prog[1]) begin
            errors++;
            $display("FAIL abort_reload: got %0d writes, first %04h want 2 writes %04h %04h",
                     wr_addr.size() - base, wr_data[base], prog[0], prog[1]);
        end
        checks++;
        if (done !== 1'b1 || cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: done=%b cpu=%b want 1 1", done, cpu_run);
        end
    endtask

    task automatic test_checksum();
`ifdef CODEMEM_LOADER_CHECKSUM_EN
        prog.delete();
        prog.push_back(16'h0102);
        pulse_start(1);
        send_words(1, 0, -1);
        drive_byte(8'hFD, 0);
        byte_valid = 1'b0;
        wait_idle();
        checks++;
        if ({done, load_err, cpu_run} !== 3'b101) begin
            errors++;
            $display("FAIL csum_good: done=%b err=%b cpu=%b want 101",
                     done, load_err, cpu_run);
        end
        pulse_start(1);
        send_words(1, 0, -1);
        drive_byte(8'hFC, 0);
        byte_valid = 1'b0;
        wait_idle();
        checks++;
        if ({done, load_err, cpu_run, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL csum_bad: done=%b err=%b cpu=%b busy=%b want 0100",
                     done, load_err, cpu_run, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_gaps();
        test_bad_count();
        test_reset_abort();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
